read_strided: RTL and testbench

//  Parametrised block-RAM reader. Generates num_iters x num_reads_per_iter read requests with a

---
 rtl/read_strided_pkg.sv | 9 +
 rtl/read_strided_fifo.sv | 47 ++++
 rtl/read_strided.sv | 147 ++++++++++++++
 tb/tb_read_strided.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/read_strided_pkg.sv
// Shared types for the strided BRAM reader: issue FSM state encoding.
package read_strided_pkg;

  typedef enum logic {
    FSM_IDLE  = 1'b0,
    FSM_ISSUE = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/read_strided_fifo.sv
// Power-of-two circular FIFO with occupancy count; write lands next cycle, head is registered storage.
// Caller must not push when full unless it also pops; pop is ignored by design only if caller respects empty.
module read_strided_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 8,
  parameter int LOG_SLOTS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic [LOG_SLOTS:0]    count
);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [LOG_SLOTS-1:0]  wr_ptr;
  logic [LOG_SLOTS-1:0]  rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + LOG_SLOTS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LOG_SLOTS'(1);
      end
      // Push and pop together leave the count unchanged, including at full.
      case ({push, pop})
        2'b10:   count <= count + (LOG_SLOTS+1)'(1);
        2'b01:   count <= count - (LOG_SLOTS+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/read_strided.sv
// Strided BRAM reader: issues num_iters x num_reads_per_iter requests, buffers returns, streams them out.
// Issue is credit-gated on FIFO occupancy plus reads in flight, so any BRAM latency is tolerated.
module read_strided
  import read_strided_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int FIFO_DEPTH             = 8,
  parameter int LOG_FIFO_DEPTH         = 3,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]        base_address,
  input  logic [LOG_MAX_ADDRESS-1:0]        stride,
  input  logic [LOG_MAX_ADDRESS-1:0]        iter_offset,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [LOG_MAX_ADDRESS-1:0]        address_out,
  output logic                              request,
  input  logic                              avail_in,
  output logic                              valid_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              busy,
  output logic                              done
);

  localparam int CNT_W = LOG_FIFO_DEPTH + 1;

  fsm_state_t                        state;
  fsm_state_t                        state_next;
  logic                              enabled;
  logic [LOG_MAX_ITERS-1:0]          iters_left;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_left;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_cfg;
  logic [LOG_MAX_ADDRESS-1:0]        stride_cfg;
  logic [LOG_MAX_ADDRESS-1:0]        offset_cfg;
  logic [LOG_MAX_ADDRESS-1:0]        iter_base;
  logic [LOG_MAX_ADDRESS-1:0]        addr;
  logic [LOG_MAX_ADDRESS-1:0]        next_base;
  logic [CNT_W-1:0]                  inflight;
  logic [CNT_W-1:0]                  fifo_count;
  logic                              fifo_empty;
  logic                              credit;
  logic                              push;
  logic                              cfg_ok;
  logic                              busy_q;
  logic                              zero_pulse;

  // Reserved slots = data already buffered + data still coming back from the BRAM.
  assign credit    = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);
  assign push      = valid_in & (inflight != '0);
  assign valid_out = avail_in & ~fifo_empty;
  assign busy      = enabled | (inflight != '0) | ~fifo_empty;
  assign done      = (busy_q & ~busy) | zero_pulse;
  assign cfg_ok    = configure & ~busy;
  assign next_base = iter_base + offset_cfg;
  assign address_out = addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FSM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = FSM_IDLE;
    request    = 1'b0;
    case (state)
      FSM_IDLE: begin
        if (enabled && credit) state_next = FSM_ISSUE;
      end
      FSM_ISSUE: begin
        request = enabled & credit;
        if (enabled && credit) state_next = FSM_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      enabled    <= 1'b0;
      iters_left <= '0;
      reads_left <= '0;
      reads_cfg  <= '0;
      stride_cfg <= '0;
      offset_cfg <= '0;
      iter_base  <= '0;
      addr       <= '0;
      inflight   <= '0;
      busy_q     <= 1'b0;
      zero_pulse <= 1'b0;
    end else begin
      busy_q     <= busy;
      zero_pulse <= cfg_ok & ((num_iters == '0) | (num_reads_per_iter == '0));
      if (cfg_ok) begin
        enabled    <= (num_iters != '0) && (num_reads_per_iter != '0);
        iters_left <= num_iters;
        reads_left <= num_reads_per_iter;
        reads_cfg  <= num_reads_per_iter;
        stride_cfg <= stride;
        offset_cfg <= iter_offset;
        iter_base  <= base_address;
        addr       <= base_address;
      end else if (request) begin
        if (reads_left == LOG_MAX_READS_PER_ITER'(1)) begin
          iter_base  <= next_base;
          addr       <= next_base;
          reads_left <= reads_cfg;
          iters_left <= iters_left - LOG_MAX_ITERS'(1);
          if (iters_left == LOG_MAX_ITERS'(1)) enabled <= 1'b0;
        end else begin
          addr       <= addr + stride_cfg;
          reads_left <= reads_left - LOG_MAX_READS_PER_ITER'(1);
        end
      end
      // A stray return with nothing outstanding is dropped, so it never decrements.
      case ({request, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  read_strided_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLOTS  (FIFO_DEPTH),
    .LOG_SLOTS  (LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_in),
    .pop       (valid_out),
    .head      (data_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_read_strided.sv
// Bench for read_strided: BRAM model with programmable latency plus a queue-based reference of the request/data streams.
module tb_read_strided;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        configure = 1'b0;
  logic [15:0] num_iters = '0;
  logic [15:0] num_reads_per_iter = '0;
  logic [15:0] base_address = '0;
  logic [15:0] stride = '0;
  logic [15:0] iter_offset = '0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = '0;
  logic [15:0] address_out;
  logic        request;
  logic        avail_in = 1'b1;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        busy;
  logic        done;

  read_strided #(
    .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .LOG_FIFO_DEPTH(2),
    .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16), .LOG_MAX_ADDRESS(16)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .base_address(base_address),
    .stride(stride), .iter_offset(iter_offset), .valid_in(valid_in),
    .data_in(data_in), .address_out(address_out), .request(request),
    .avail_in(avail_in), .valid_out(valid_out), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] d;
  } bram_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bram_t       bq[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [15:0] addr_log[$];
  int          infl = 0;
  int          occ = 0;
  bit          prev_busy = 0;
  bit          zero_pend = 0;
  bit          done_seen = 0;
  int          done_cyc = 0;
  int          last_out_cyc = 0;
  int          out_cnt = 0;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: request/data stream from closed-form addresses; occupancy from counts.
  task automatic compare_cycle();
    bit exp_busy;
    bit push_ok;
    if (!rst) begin
      exp_addr.delete();
      exp_data.delete();
      infl = 0;
      occ = 0;
      prev_busy = 0;
      zero_pend = 0;
      return;
    end
    exp_busy = (exp_addr.size() > 0) || (infl > 0) || (occ > 0);
    chk("busy", busy, exp_busy);
    chk("done", done, (prev_busy && !exp_busy) || zero_pend);
    chk("valid_out", valid_out, avail_in && (occ > 0));
    if (valid_out && exp_data.size() > 0) begin
      chk("data_out", data_out, exp_data[0]);
      void'(exp_data.pop_front());
    end
    if (request) begin
      if (infl + occ >= DEPTH) chk("request_credit", request, 0);
      if (exp_addr.size() == 0) begin
        chk("request_extra", request, 0);
      end else begin
        chk("address_out", address_out, exp_addr[0]);
        void'(exp_addr.pop_front());
      end
      bq.push_back('{due: cyc + lat, d: memf(address_out)});
      exp_data.push_back(memf(address_out));
      addr_log.push_back(address_out);
    end
    if (done) begin
      done_seen = 1;
      done_cyc = cyc;
    end
    if (valid_out) begin
      last_out_cyc = cyc;
      out_cnt++;
    end
    push_ok = valid_in && (infl > 0);
    occ  = occ + int'(push_ok) - int'(valid_out);
    infl = infl + int'(request) - int'(push_ok);
    prev_busy = exp_busy;
    zero_pend = 0;
    if (configure && !exp_busy) begin
      if (num_iters == 0 || num_reads_per_iter == 0) zero_pend = 1;
      for (int i = 0; i < int'(num_iters); i++)
        for (int j = 0; j < int'(num_reads_per_iter); j++)
          exp_addr.push_back(16'(base_address + i * iter_offset + j * stride));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (bq.size() > 0 && bq[0].due == cyc) begin
      valid_in = 1'b1;
      data_in = bq[0].d;
      void'(bq.pop_front());
    end else begin
      valid_in = 1'b0;
      data_in = '0;
    end
  endtask

  task automatic cfg(input logic [15:0] b, input logic [15:0] s, input logic [15:0] o,
                     input logic [15:0] it, input logic [15:0] rd);
    base_address = b; stride = s; iter_offset = o;
    num_iters = it; num_reads_per_iter = rd;
    configure = 1'b1;
    tick();
    configure = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    done_seen = 0;
    for (int i = 0; i < budget && !done_seen; i++) tick();
    if (!done_seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_log(input string name, input logic [15:0] exp[$]);
    chk({name, "_count"}, addr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < addr_log.size(); i++)
      chk({name, "_addr"}, addr_log[i], exp[i]);
  endtask

  initial begin
    int outs0;
    tick();
    tick();
    chk("rst_request", request, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_address", address_out, 16'h0000);
    rst = 1'b1;
    tick();

    // Repeating window, latency 1.
    lat = 1; avail_in = 1'b1; addr_log.delete(); out_cnt = 0;
    cfg(16'h0010, 16'd2, 16'h0000, 16'd2, 16'd3);
    wait_done("t1", 200);
    chk_log("t1", '{16'h10, 16'h12, 16'h14, 16'h10, 16'h12, 16'h14});
    chk("t1_outputs", out_cnt, 6);
    chk("t1_done_timing", done_cyc, last_out_cyc + 1);

    // Per-iteration offset.
    addr_log.delete();
    cfg(16'h0000, 16'd1, 16'h0100, 16'd3, 16'd2);
    wait_done("t2", 200);
    chk_log("t2", '{16'h000, 16'h001, 16'h100, 16'h101, 16'h200, 16'h201});

    // Credit stall with downstream blocked, latency 3.
    lat = 3; avail_in = 1'b0; addr_log.delete(); out_cnt = 0;
    cfg(16'h0040, 16'd1, 16'h0000, 16'd1, 16'd8);
    for (int i = 0; i < 30; i++) tick();
    chk("t3_stalled_requests", addr_log.size(), 4);
    chk("t3_request_low", request, 0);
    avail_in = 1'b1;
    wait_done("t3", 300);
    chk("t3_outputs", out_cnt, 8);
    chk("t3_requests", addr_log.size(), 8);

    // Address wrap.
    lat = 2; addr_log.delete();
    cfg(16'hFFFE, 16'd1, 16'h0000, 16'd1, 16'd4);
    wait_done("t4", 200);
    chk_log("t4", '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});

    // Zero iterations.
    addr_log.delete();
    cfg(16'h0005, 16'd1, 16'd1, 16'd0, 16'd3);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_requests", addr_log.size(), 0);

    // Configure while busy is ignored.
    lat = 1; addr_log.delete();
    cfg(16'h0020, 16'd1, 16'h0000, 16'd1, 16'd4);
    for (int i = 0; i < 3; i++) tick();
    cfg(16'h0080, 16'd4, 16'h0000, 16'd2, 16'd2);
    wait_done("t6", 200);
    chk_log("t6", '{16'h20, 16'h21, 16'h22, 16'h23});

    // Reset mid-stream with reads in flight.
    lat = 3; addr_log.delete();
    cfg(16'h0030, 16'd1, 16'h0000, 16'd1, 16'd6);
    for (int i = 0; i < 50 && addr_log.size() < 2; i++) tick();
    chk("t7_two_issued", addr_log.size(), 2);
    rst = 1'b0;
    tick();
    chk("t7_request", request, 0);
    chk("t7_valid_out", valid_out, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_address", address_out, 16'h0000);
    rst = 1'b1;
    outs0 = out_cnt;
    for (int i = 0; i < 8; i++) tick();
    chk("t7_stale_dropped", out_cnt, outs0);
    chk("t7_idle", busy, 0);
    lat = 1; addr_log.delete();
    cfg(16'h0060, 16'd3, 16'h0000, 16'd1, 16'd3);
    wait_done("t7", 200);
    chk_log("t7", '{16'h60, 16'h63, 16'h66});
    chk("t7_outputs", out_cnt, outs0 + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
